text_pixel_fetch: RTL and testbench
===================================

Name: text_pixel_fetch

Overview:
- Upstream stage of the display pixel generator.
- Holds the 20x15 text-cell character buffer. Each cell is 32x32 screen pixels, and the editor writes into the buffer.
- For every VGA coordinate, fetches the cell's character code, drives an external 8x8 font ROM and produces the 1-bit word_pixel.
- Also emits h_cnt/v_cnt/valid delayed to stay aligned with word_pixel.

Parameters:
- COLS, 20, text cells per row (640/32)
- ROWS, 15, text cell rows (480/32)
- CHAR_W, 7, character code width
- CELLS, 300, COLS*ROWS, buffer depth

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  VGA active-video flag
- h_cnt  in  10  VGA horizontal count
- v_cnt  in  10  VGA vertical count
- wr_en  in  1  editor write strobe, single cycle
- wr_x  in  5  target cell column
- wr_y  in  5  target cell row
- wr_char  in  CHAR_W  code to store
- clear_req  in  1  pulse: blank the whole buffer
- busy  out  1  clear sequence in progress
- font_addr  out  CHAR_W+3  {char, glyph_row} to external ROM
- font_row  in  8  ROM data; registered ROM, 1-cycle latency; bit7 = leftmost pixel
- word_pixel  out  1  glyph pixel, aligned with *_o outputs
- valid_o  out  1  valid delayed 3 cycles
- h_cnt_o  out  10  h_cnt delayed 3 cycles
- v_cnt_o  out  10  v_cnt delayed 3 cycles

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - word_pixel=0, valid_o=0, h_cnt_o=0, v_cnt_o=0, font_addr=0, all pipeline registers 0.
  - busy=1 while rst is high.
  - The buffer is not reset in one cycle. Instead, reset arms the clear FSM: the sweep starts on the first cycle with rst low.
- Cell mapping:
  - cx = h_cnt[9:5], cy = v_cnt[9:5], index = cy*COLS + cx (9-bit unsigned).
  - cx>=COLS or cy>=ROWS counts as out of range: treated as char 0.
  - Glyphs are scaled x4: glyph_row = v_cnt[4:2], glyph_col = h_cnt[4:2].
- Pipeline, coordinate presented at edge t:
  - S1 (t+1): registered buffer read gives char_q; forced to 0 when out of range or valid=0. h, v and valid are registered alongside.
  - S2: font_addr = {char_q, v_d1[4:2]} driven combinationally from S1 registers; the ROM returns font_row at t+2.
  - S3 (t+3): word_pixel = (char_d2 != 0) & valid_d2 & font_row[7 - h_d2[4:2]]. *_o outputs are registered alongside.
  - Total latency is exactly 3 cycles. Throughput is 1 pixel per clock with no stalls.
- Char code 0 always renders blank, whatever the ROM returns.
- Write port:
  - With wr_en=1, busy=0 and coordinates in range, wr_char is stored at the edge.
  - The display read at that same edge sees the old value; reads from the next edge onward see the new one.
  - Out-of-range writes are dropped silently.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req, or on the first cycle after rst. The counter loads 0 and busy=1.
  - CLEAR writes 0 to cell[cnt] each cycle, cnt+1.
  - When cnt reaches CELLS-1, the last write happens, then the FSM moves to IDLE; busy falls on the following cycle. A clear therefore takes exactly 300 busy cycles.
  - clear_req while busy: ignored; no restart.
  - wr_en while busy, or in the same cycle as clear_req: the write is dropped.
  - rst mid-clear: the counter restarts at 0 after rst falls.
- The display pipeline keeps running during a clear and shows partially cleared contents; this is intentional.

Optional Feature:
- Macro: TEXT_PIXEL_CURSOR_EN.
- With the macro defined:
  - Adds inputs cur_x[4:0], cur_y[4:0] and cur_on.
  - A 25-bit free-running blink counter is added; it resets to 0.
  - Inside cell (cur_x, cur_y), when cur_on=1 and counter bit 24 = 1, word_pixel is forced to 1 on glyph rows 6-7 (v_cnt[4:2] >= 6). Evaluation uses the S3-aligned coordinates.
- Without the macro: no extra ports, no counter, word_pixel is exactly as above.

Test Plan:
- Reset: hold rst 4 cycles then release -> busy=1 during rst and for exactly 300 cycles after; all outputs 0 during rst; every cell reads 0 afterwards.
- Write then display: write 'A' (0x41) to cell (3,2), scan h=96..127, v=64 -> font_addr=0x208 at t+1; word_pixel at t+3 tracks the ROM row bits, each bit repeated 4 pixels.
- Alignment: feed a ramp h_cnt=0..639 with valid toggling -> h_cnt_o/v_cnt_o/valid_o equal inputs delayed exactly 3 cycles; word_pixel=0 whenever valid_o=0.
- Out of range: write to (20,0) and to (0,15) -> ignored; displaying v_cnt=479 column 19 returns the stored char; h_cnt=640..799 gives word_pixel=0.
- Clear collisions: assert clear_req and wr_en together, then wr_en and a second clear_req at busy cycle 100 -> both writes dropped, no restart, busy ends at cycle 300.
- Char 0 masking: ROM returns 0xFF for all addresses, cell holds 0 -> word_pixel stays 0 across the cell.

Source files
------------

// File: rtl/text_pixel_fetch_if.sv
// -----------------------------------------------------------------------------
// text_pixel_fetch_if
// Editor-side bus of the text pixel fetch stage: cell writes and buffer clear.
//
// Signals:
//   wr_en      editor write strobe, single cycle
//   wr_x       target cell column (0..19 valid)
//   wr_y       target cell row    (0..14 valid)
//   wr_char    character code to store
//   clear_req  pulse: blank the whole character buffer
//   busy       clear sequence in progress (writes and clear requests ignored)
//
// Modports:
//   master  editor side (drives requests, observes busy)
//   slave   text_pixel_fetch side
// -----------------------------------------------------------------------------
interface text_pixel_fetch_if #(
   parameter int CHAR_W = 7
);
   logic              wr_en;
   logic [4:0]        wr_x;
   logic [4:0]        wr_y;
   logic [CHAR_W-1:0] wr_char;
   logic              clear_req;
   logic              busy;

   modport master (
      output wr_en,
      output wr_x,
      output wr_y,
      output wr_char,
      output clear_req,
      input  busy
   );

   modport slave (
      input  wr_en,
      input  wr_x,
      input  wr_y,
      input  wr_char,
      input  clear_req,
      output busy
   );
endinterface

// File: rtl/text_pixel_fetch.sv
// -----------------------------------------------------------------------------
// text_pixel_fetch
// Upstream stage of the display pixel generator. Holds the 20x15 character
// buffer (one code per 32x32-pixel cell), looks up the cell under the current
// VGA coordinate, drives an external registered 8x8 font ROM (glyphs scaled
// x4) and produces the 1-bit word_pixel. The VGA coordinate and valid flag are
// delayed so they stay aligned with word_pixel (3-cycle latency, 1 pixel per
// clock, no stalls).
//
// Ports:
//   clk         pixel-domain clock
//   rst         synchronous, active-high reset; arms a full buffer clear
//   ed          editor bus (text_pixel_fetch_if.slave): writes, clear, busy
//   valid       VGA active-video flag
//   h_cnt       VGA horizontal count
//   v_cnt       VGA vertical count
//   font_addr   {char, glyph_row} to the external font ROM
//   font_row    ROM data, 1-cycle latency, bit7 = leftmost pixel
//   word_pixel  glyph pixel, aligned with the *_o outputs
//   valid_o     valid delayed 3 cycles
//   h_cnt_o     h_cnt delayed 3 cycles
//   v_cnt_o     v_cnt delayed 3 cycles
//
// Optional feature (macro TEXT_PIXEL_CURSOR_EN):
//   cur_x, cur_y, cur_on  blinking underline cursor on glyph rows 6-7 of the
//                         selected cell, driven by a 25-bit blink counter.
// -----------------------------------------------------------------------------
module text_pixel_fetch #(
   parameter int COLS   = 20,
   parameter int ROWS   = 15,
   parameter int CHAR_W = 7,
   parameter int CELLS  = COLS * ROWS
) (
   input  logic                clk,
   input  logic                rst,
   text_pixel_fetch_if.slave   ed,
   input  logic                valid,
   input  logic [9:0]          h_cnt,
   input  logic [9:0]          v_cnt,
   output logic [CHAR_W+2:0]   font_addr,
   input  logic [7:0]          font_row,
   output logic                word_pixel,
   output logic                valid_o,
   output logic [9:0]          h_cnt_o,
   output logic [9:0]          v_cnt_o
`ifdef TEXT_PIXEL_CURSOR_EN
   ,
   input  logic [4:0]          cur_x,
   input  logic [4:0]          cur_y,
   input  logic                cur_on
`endif
);

   localparam logic [4:0] COLS5 = 5'(COLS);
   localparam logic [4:0] ROWS5 = 5'(ROWS);
   localparam logic [8:0] COLS9 = 9'(COLS);
   localparam logic [8:0] LAST  = 9'(CELLS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   // Clear sequencer
   state_t            r_state;
   logic [8:0]        r_cnt;
   logic              r_busy;

   // Character buffer
   logic [CHAR_W-1:0] r_mem [CELLS];

   // Write-side decode
   logic              w_wr_inrange;
   logic [8:0]        w_wr_idx;
   logic              w_ed_we;
   logic              w_clr_we;
   logic              w_we;
   logic [8:0]        w_waddr;
   logic [CHAR_W-1:0] w_wdata;

   // Read-side decode
   logic [4:0]        w_rd_cx;
   logic [4:0]        w_rd_cy;
   logic              w_rd_inrange;
   logic [8:0]        w_rd_idx;
   logic [CHAR_W-1:0] w_rd_char;

   // Pipeline registers
   logic [CHAR_W-1:0] r_char_p1;
   logic [9:0]        r_h_p1;
   logic [9:0]        r_v_p1;
   logic              r_vld_p1;
   logic [CHAR_W-1:0] r_char_p2;
   logic [9:0]        r_h_p2;
   logic [9:0]        r_v_p2;
   logic              r_vld_p2;
   logic              r_pix_p3;
   logic [9:0]        r_h_p3;
   logic [9:0]        r_v_p3;
   logic              r_vld_p3;

   logic              w_glyph_bit;
   logic              w_cur_hit;
   logic              w_pix;

   // ---------------------------------------------------------------------------
   // Clear FSM: sweeps every cell to 0, one per cycle. Reset leaves it armed
   // in CLEAR with the counter at 0, so the sweep starts when rst drops.
   // busy mirrors "state == CLEAR" as a register.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ed.clear_req) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == LAST) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 9'd1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ed.busy = r_busy;

   // ---------------------------------------------------------------------------
   // Buffer write port. The clear sweep owns the port while busy; an editor
   // write is dropped while busy, in the cycle a clear is requested, during
   // reset, or when it targets a cell outside the 20x15 grid.
   // ---------------------------------------------------------------------------
   assign w_wr_inrange = (ed.wr_x < COLS5) && (ed.wr_y < ROWS5);
   assign w_wr_idx     = ({4'd0, ed.wr_y} * COLS9) + {4'd0, ed.wr_x};
   assign w_ed_we      = ed.wr_en && !r_busy && !ed.clear_req && !rst && w_wr_inrange;
   assign w_clr_we     = (r_state == ST_CLEAR) && !rst;
   assign w_we         = w_clr_we || w_ed_we;
   assign w_waddr      = w_clr_we ? r_cnt : w_wr_idx;
   assign w_wdata      = w_clr_we ? '0 : ed.wr_char;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Read address: cell under the current coordinate. Off-grid or blanked
   // coordinates are forced to char 0, which always renders blank.
   // ---------------------------------------------------------------------------
   assign w_rd_cx      = h_cnt[9:5];
   assign w_rd_cy      = v_cnt[9:5];
   assign w_rd_inrange = (w_rd_cx < COLS5) && (w_rd_cy < ROWS5);
   assign w_rd_idx     = ({4'd0, w_rd_cy} * COLS9) + {4'd0, w_rd_cx};
   assign w_rd_char    = (valid && w_rd_inrange) ? r_mem[w_rd_idx] : '0;

   // ---- S1: registered buffer read, coordinate captured alongside ----------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_char_p1 <= '0;
         r_h_p1    <= '0;
         r_v_p1    <= '0;
         r_vld_p1  <= 1'b0;
      end else begin
         r_char_p1 <= w_rd_char;
         r_h_p1    <= h_cnt;
         r_v_p1    <= v_cnt;
         r_vld_p1  <= valid;
      end
   end

   // Glyphs are scaled x4, so v_cnt[4:2] selects the glyph row.
   assign font_addr = {r_char_p1, r_v_p1[4:2]};

   // ---- S2: ROM access in flight; carry the context it needs at S3 ---------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_char_p2 <= '0;
         r_h_p2    <= '0;
         r_v_p2    <= '0;
         r_vld_p2  <= 1'b0;
      end else begin
         r_char_p2 <= r_char_p1;
         r_h_p2    <= r_h_p1;
         r_v_p2    <= r_v_p1;
         r_vld_p2  <= r_vld_p1;
      end
   end

   // bit7 is the leftmost glyph column; h_cnt[4:2] is the glyph column.
   assign w_glyph_bit = font_row[3'd7 - r_h_p2[4:2]];

`ifdef TEXT_PIXEL_CURSOR_EN
   logic [24:0] r_blink;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink <= '0;
      end else begin
         r_blink <= r_blink + 25'd1;
      end
   end

   // Underline on glyph rows 6-7 of the cursor cell, lit during the upper
   // half of the blink period.
   assign w_cur_hit = cur_on && r_blink[24] && r_vld_p2 &&
                      (r_h_p2[9:5] == cur_x) && (r_v_p2[9:5] == cur_y) &&
                      (r_v_p2[4:2] >= 3'd6);
`else
   assign w_cur_hit = 1'b0;
`endif

   assign w_pix = ((r_char_p2 != '0) && r_vld_p2 && w_glyph_bit) || w_cur_hit;

   // ---- S3: output register, pixel aligned with delayed coordinate ---------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pix_p3 <= 1'b0;
         r_h_p3   <= '0;
         r_v_p3   <= '0;
         r_vld_p3 <= 1'b0;
      end else begin
         r_pix_p3 <= w_pix;
         r_h_p3   <= r_h_p2;
         r_v_p3   <= r_v_p2;
         r_vld_p3 <= r_vld_p2;
      end
   end

   assign word_pixel = r_pix_p3;
   assign h_cnt_o    = r_h_p3;
   assign v_cnt_o    = r_v_p3;
   assign valid_o    = r_vld_p3;

endmodule

// File: tb/tb_text_pixel_fetch.sv
module tb_text_pixel_fetch;
   localparam int CHAR_W = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid;
   logic [9:0]        h_cnt;
   logic [9:0]        v_cnt;
   logic [CHAR_W+2:0] font_addr;
   logic [7:0]        font_row;
   logic              word_pixel;
   logic              valid_o;
   logic [9:0]        h_cnt_o;
   logic [9:0]        v_cnt_o;
   logic              rom_ff;

   int n_checks = 0;
   int n_errors = 0;

   text_pixel_fetch_if #(.CHAR_W(CHAR_W)) ed_if ();

`ifdef TEXT_PIXEL_CURSOR_EN
   logic [4:0] cur_x  = 5'd0;
   logic [4:0] cur_y  = 5'd0;
   logic       cur_on = 1'b0;
`endif

   text_pixel_fetch dut (
      .clk        (clk),
      .rst        (rst),
      .ed         (ed_if),
      .valid      (valid),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .font_addr  (font_addr),
      .font_row   (font_row),
      .word_pixel (word_pixel),
      .valid_o    (valid_o),
      .h_cnt_o    (h_cnt_o),
      .v_cnt_o    (v_cnt_o)
`ifdef TEXT_PIXEL_CURSOR_EN
      ,
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .cur_on     (cur_on)
`endif
   );

   always #5 clk = ~clk;

   // Font ROM model: registered, 1-cycle latency; either a fixed pattern or all ones.
   function automatic logic [7:0] rom_val(input logic [9:0] a, input logic ff);
      return ff ? 8'hFF : (8'(a * 10'd37) ^ 8'h5C);
   endfunction

   always_ff @(posedge clk) font_row <= rom_val(font_addr, rom_ff);

   // Shadow copy of the character buffer.
   logic [6:0] shadow [300];

   function automatic logic [6:0] model_char(input logic vl, input logic [9:0] h, input logic [9:0] v);
      int cx = int'(h[9:5]);
      int cy = int'(v[9:5]);
      if (!vl || cx >= 20 || cy >= 15) return 7'd0;
      return shadow[cy * 20 + cx];
   endfunction

   function automatic logic model_pix(input logic vl, input logic [9:0] h, input logic [9:0] v);
      logic [6:0] c;
      logic [7:0] r;
      int         col;
      c   = model_char(vl, h, v);
      r   = rom_val({c, v[4:2]}, rom_ff);
      col = 7 - int'(h[4:2]);
      return (c != 7'd0) && vl && r[col];
   endfunction

   typedef struct {
      logic       vld;
      logic [9:0] h;
      logic [9:0] v;
      logic       pix;
   } exp_t;
   exp_t q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One pixel clock: present a coordinate, check font_addr one edge later and
   // the {valid_o,h_cnt_o,v_cnt_o,word_pixel} bundle for the coordinate
   // presented two calls earlier (three edges of pipeline in total).
   task automatic cyc(input logic vl, input logic [9:0] h, input logic [9:0] v);
      exp_t       e;
      exp_t       o;
      logic [9:0] ea;
      valid = vl;
      h_cnt = h;
      v_cnt = v;
      e.vld = vl;
      e.h   = h;
      e.v   = v;
      e.pix = model_pix(vl, h, v);
      ea    = {model_char(vl, h, v), v[4:2]};
      @(posedge clk);
      #1;
      check("font_addr", 32'(font_addr), 32'(ea));
      q.push_back(e);
      if (q.size() >= 3) begin
         o = q.pop_front();
         check("pipe_out{vld,h,v,pix}", 32'({valid_o, h_cnt_o, v_cnt_o, word_pixel}),
               32'({o.vld, o.h, o.v, o.pix}));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 10'd0, 10'd0);
   endtask

   task automatic wr(input int x, input int y, input logic [6:0] c, input logic acc,
                     input logic dv, input logic [9:0] dh, input logic [9:0] dvv);
      ed_if.wr_en   = 1'b1;
      ed_if.wr_x    = 5'(x);
      ed_if.wr_y    = 5'(y);
      ed_if.wr_char = c;
      cyc(dv, dh, dvv);
      ed_if.wr_en = 1'b0;
      if (acc) shadow[y * 20 + x] = c;
   endtask

   task automatic scan_cell(input int cx, input int cy, input int grow);
      for (int i = 0; i < 32; i++) cyc(1'b1, 10'(cx * 32 + i), 10'(cy * 32 + grow * 4 + 1));
   endtask

   task automatic wait_busy(inout int n, input int limit);
      while (ed_if.busy && n < limit) begin
         cyc(1'b0, 10'd0, 10'd0);
         n++;
      end
   endtask

   typedef struct {
      int         x;
      int         y;
      logic [6:0] ch;
      logic       acc;
      logic [9:0] dh;
      logic [9:0] dv;
      logic [9:0] exp_addr;
   } vec_t;

   initial begin
      vec_t tbl[7];
      exp_t z;
      int   n;

      tbl[0] = '{x: 3,  y: 2,  ch: 7'h41, acc: 1'b1, dh: 10'd96,  dv: 10'd64,  exp_addr: 10'h208};
      tbl[1] = '{x: 20, y: 0,  ch: 7'h11, acc: 1'b0, dh: 10'd0,   dv: 10'd44,  exp_addr: 10'h003};
      tbl[2] = '{x: 0,  y: 15, ch: 7'h22, acc: 1'b0, dh: 10'd0,   dv: 10'd8,   exp_addr: 10'h002};
      tbl[3] = '{x: 19, y: 14, ch: 7'h7F, acc: 1'b1, dh: 10'd608, dv: 10'd479, exp_addr: 10'h3FF};
      tbl[4] = '{x: 0,  y: 0,  ch: 7'h01, acc: 1'b1, dh: 10'd0,   dv: 10'd4,   exp_addr: 10'h009};
      tbl[5] = '{x: 10, y: 7,  ch: 7'h2A, acc: 1'b1, dh: 10'd320, dv: 10'd244, exp_addr: 10'h155};
      tbl[6] = '{x: 31, y: 31, ch: 7'h05, acc: 1'b0, dh: 10'd640, dv: 10'd0,   exp_addr: 10'h000};

      for (int i = 0; i < 300; i++) shadow[i] = 7'd0;
      rst             = 1'b1;
      valid           = 1'b0;
      h_cnt           = 10'd0;
      v_cnt           = 10'd0;
      rom_ff          = 1'b0;
      ed_if.wr_en     = 1'b0;
      ed_if.wr_x      = 5'd0;
      ed_if.wr_y      = 5'd0;
      ed_if.wr_char   = 7'd0;
      ed_if.clear_req = 1'b0;

      // Reset: outputs held at 0, busy high.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("rst_busy", 32'(ed_if.busy), 32'd1);
         check("rst_word_pixel", 32'(word_pixel), 32'd0);
         check("rst_valid_o", 32'(valid_o), 32'd0);
         check("rst_h_cnt_o", 32'(h_cnt_o), 32'd0);
         check("rst_v_cnt_o", 32'(v_cnt_o), 32'd0);
         check("rst_font_addr", 32'(font_addr), 32'd0);
      end
      rst = 1'b0;
      z   = '{vld: 1'b0, h: 10'd0, v: 10'd0, pix: 1'b0};
      q.delete();
      q.push_back(z);
      q.push_back(z);

      // Power-on clear lasts 300 busy cycles after rst falls.
      n = 0;
      wait_busy(n, 400);
      check("reset_clear_len", 32'(n), 32'd300);

      // Every cell reads 0 (ROM returns 0xFF, so any nonzero char would light).
      rom_ff = 1'b1;
      for (int cy = 0; cy < 15; cy++)
         for (int cx = 0; cx < 20; cx++)
            cyc(1'b1, 10'(cx * 32 + 13), 10'(cy * 32 + 9));
      idle(3);
      rom_ff = 1'b0;
      idle(3);

      // Table-driven writes, including dropped out-of-range ones.
      for (int i = 0; i < 7; i++) begin
         wr(tbl[i].x, tbl[i].y, tbl[i].ch, tbl[i].acc, 1'b0, 10'd0, 10'd0);
         cyc(1'b1, tbl[i].dh, tbl[i].dv);
         check("tbl_font_addr", 32'(font_addr), 32'(tbl[i].exp_addr));
         for (int p = 0; p < 32; p++) cyc(1'b1, {tbl[i].dh[9:5], 5'(p)}, tbl[i].dv);
         idle(2);
      end

      // Write and display the same cell on the same edge: old code first.
      wr(3, 2, 7'h42, 1'b1, 1'b1, 10'd104, 10'd68);
      check("same_edge_old", 32'(font_addr), 32'h209);
      cyc(1'b1, 10'd104, 10'd68);
      check("next_edge_new", 32'(font_addr), 32'h211);
      wr(3, 2, 7'h41, 1'b1, 1'b0, 10'd0, 10'd0);

      // 'A' at (3,2), h=96..127, v=64.
      for (int h = 96; h < 128; h++) cyc(1'b1, 10'(h), 10'd64);

      // Alignment ramp with valid toggling.
      for (int h = 0; h < 640; h++) cyc((h % 3) != 0, 10'(h), 10'd72);

      // Bottom-right cell and horizontal blanking region.
      scan_cell(19, 14, 7);
      for (int h = 640; h < 800; h++) cyc(1'b1, 10'(h), 10'd479);
      idle(3);

      // Clear collisions: write with clear_req, then write + clear_req at busy cycle 100.
      ed_if.clear_req = 1'b1;
      ed_if.wr_en     = 1'b1;
      ed_if.wr_x      = 5'd0;
      ed_if.wr_y      = 5'd0;
      ed_if.wr_char   = 7'h55;
      cyc(1'b0, 10'd0, 10'd0);
      ed_if.clear_req = 1'b0;
      ed_if.wr_en     = 1'b0;
      for (int i = 0; i < 300; i++) shadow[i] = 7'd0;
      check("clear_busy_start", 32'(ed_if.busy), 32'd1);
      n = 0;
      for (int i = 0; i < 99; i++) begin
         cyc(1'b0, 10'd0, 10'd0);
         n++;
      end
      ed_if.clear_req = 1'b1;
      ed_if.wr_en     = 1'b1;
      ed_if.wr_char   = 7'h66;
      cyc(1'b0, 10'd0, 10'd0);
      n++;
      ed_if.clear_req = 1'b0;
      ed_if.wr_en     = 1'b0;
      check("clear_busy_mid", 32'(ed_if.busy), 32'd1);
      wait_busy(n, 400);
      check("clear_len_no_restart", 32'(n), 32'd300);

      // Char 0 masking with an all-ones ROM.
      idle(3);
      rom_ff = 1'b1;
      for (int r = 0; r < 8; r++) scan_cell(0, 0, r);
      scan_cell(3, 2, 2);
      wr(3, 2, 7'h41, 1'b1, 1'b0, 10'd0, 10'd0);
      scan_cell(3, 2, 5);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
